// File: rtl/sequenciador_pkg.sv
// rtl/sequenciador_pkg.sv - shared word width and controller state encoding
package sequenciador_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        XFORM,
        EMIT,
        FINISH
    } state_t;

endpackage

// File: rtl/manipular_vetores.sv
// rtl/manipular_vetores.sv - combinational word transform: byte reverse, rotate left 4, flip low half
module manipular_vetores
    import sequenciador_pkg::*;
(
    input  logic [WORD_W-1:0] entrada,
    output logic [WORD_W-1:0] saida
);

    logic [WORD_W-1:0] swapped;
    logic [WORD_W-1:0] rotated;

    assign swapped = {entrada[7:0], entrada[15:8], entrada[23:16], entrada[31:24]};
    assign rotated = {swapped[WORD_W-5:0], swapped[WORD_W-1:WORD_W-4]};
    assign saida   = rotated ^ 32'h0000_FFFF;

endmodule

// File: rtl/sequenciador_vetores.sv
// rtl/sequenciador_vetores.sv - buffers words and streams each through manipular_vetores
module sequenciador_vetores
    import sequenciador_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              start,
    input  logic [AW:0]       count,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [AW-1:0]     out_index,
    output logic              done,
    output logic              err
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t            state;
    state_t            next_state;
    logic [WORD_W-1:0] buf_mem [DEPTH];
    logic [WORD_W-1:0] in_reg;
    logic [WORD_W-1:0] xform_word;
    logic [AW-1:0]     idx;
    logic [AW:0]       cnt;
    logic              go;
    logic              last;

    manipular_vetores u_manipular (
        .entrada (in_reg),
        .saida   (xform_word)
    );

    assign last      = ({1'b0, idx} == (cnt - 1'b1));
    assign busy      = (state != IDLE);
    assign out_valid = (state == EMIT);
    assign done      = (state == FINISH);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (go) next_state = (cnt == '0) ? FINISH : FETCH;
            FETCH:   next_state = XFORM;
            XFORM:   next_state = EMIT;
            EMIT:    if (out_ready) next_state = last ? FINISH : FETCH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A sampled start is held for one IDLE cycle in go, so a same-cycle write lands first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            go        <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            in_reg    <= '0;
            out_data  <= '0;
            out_index <= '0;
            for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
        end else begin
            state <= next_state;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_en) buf_mem[wr_addr] <= wr_data;
                    if (go) begin
                        go  <= 1'b0;
                        idx <= '0;
                    end else if (start) begin
                        if (count > DEPTH_W) begin
                            err <= 1'b1;
                        end else begin
                            go  <= 1'b1;
                            cnt <= count;
                        end
                    end
                end
                FETCH: in_reg <= buf_mem[idx];
                XFORM: begin
                    out_data  <= xform_word;
                    out_index <= idx;
                end
                EMIT: if (out_ready && !last) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_vetores.sv
// tb/tb_sequenciador_vetores.sv - directed self-checking bench for sequenciador_vetores
module tb_sequenciador_vetores;
    import sequenciador_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [WORD_W-1:0] wr_data = '0;
    logic              start = 1'b0;
    logic [AW:0]       count = '0;
    logic              busy;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WORD_W-1:0] out_data;
    logic [AW-1:0]     out_index;
    logic              done;
    logic              err;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0] words  [4] = '{32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [31:0] golden [4] = '{32'h8563_BED8, 32'hFBEA_2211, 32'h0000_FFFF, 32'hFFFF_0000};

    sequenciador_vetores #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .count     (count),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_all();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = words[i];
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic do_start(input int n);
        start = 1'b1; count = (AW+1)'(n);
        step();
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 20 && !out_valid; k++) step();
        check(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic take(input int i, input string tag);
        wait_valid({tag, "_valid"});
        check({tag, "_index"}, 32'(out_index), 32'(i));
        check({tag, "_data"}, out_data, golden[i]);
        step();
    endtask

    initial begin
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", out_data, 0);
        check("rst_done_err", {30'd0, done, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Full run, consumer always ready, latency from the start-sampling edge
        load_all();
        out_ready = 1'b1;
        do_start(4);
        check("t1_busy_pending", 32'(busy), 0);
        step();
        check("t1_valid_n1", 32'(out_valid), 0);
        step();
        check("t1_valid_n2", 32'(out_valid), 0);
        step();
        check("t1_valid_n3", 32'(out_valid), 1);
        for (int i = 0; i < 4; i++) take(i, "t1");
        check("t1_done", 32'(done), 1);
        check("t1_valid_off", 32'(out_valid), 0);
        step();
        check("t1_done_pulse", 32'(done), 0);
        check("t1_busy_after", 32'(busy), 0);

        // Backpressure holds the first word stable
        out_ready = 1'b0;
        do_start(2);
        wait_valid("t2_valid");
        for (int c = 0; c < 5; c++) begin
            step();
            check("t2_hold_valid", 32'(out_valid), 1);
            check("t2_hold_index", 32'(out_index), 0);
            check("t2_hold_data", out_data, golden[0]);
        end
        out_ready = 1'b1;
        take(0, "t2_w0");
        take(1, "t2_w1");
        check("t2_done", 32'(done), 1);
        step();
        check("t2_done_once", 32'(done), 0);
        check("t2_no_more", 32'(out_valid), 0);

        // Zero-length run and oversize count
        do_start(0);
        check("t3_done_early", 32'(done), 0);
        step();
        check("t3_done", 32'(done), 1);
        step();
        check("t3_done_off", 32'(done), 0);
        check("t3_valid", 32'(out_valid), 0);
        do_start(5);
        check("t3_err", 32'(err), 1);
        check("t3_err_busy", 32'(busy), 0);
        check("t3_err_done", 32'(done), 0);
        step();
        check("t3_err_pulse", 32'(err), 0);
        check("t3_err_idle", {30'd0, busy, done}, 0);

        // Writes and starts during a run are ignored
        do_start(2);
        step();
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 32'hCAFE_BABE;
        start = 1'b1; count = 3'd4;
        step();
        wr_en = 1'b0; start = 1'b0;
        take(0, "t4_w0");
        take(1, "t4_w1");
        check("t4_done", 32'(done), 1);
        begin
            int extra = 0;
            for (int c = 0; c < 8; c++) begin
                step();
                extra += int'(done) + int'(out_valid) + int'(busy);
            end
            check("t4_no_restart", 32'(extra), 0);
        end

        // Asynchronous reset in the middle of EMIT
        out_ready = 1'b0;
        do_start(1);
        wait_valid("t5_valid");
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_data", out_data, 0);
        step();
        check("t5_rst_done", 32'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        do_start(1);
        wait_valid("t5_post_valid");
        check("t5_post_index", 32'(out_index), 0);
        check("t5_post_data", out_data, 32'h0000_FFFF);
        step();
        check("t5_post_done", 32'(done), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sequenciador_vetores.md
Name: sequenciador_vetores

Overview:
Controller that sequences the existing combinational 32-bit vector-manipulation datapath (manipular_vetores) over a small block of words. Software/testbench loads up to DEPTH words into an internal buffer, pulses start, and the block feeds each word through manipular_vetores in order. Each result is presented on a valid/ready output stream. Sits between a simple write-port loader and any downstream consumer of transformed words.

Parameters:
DEPTH, 4, number of buffer entries (power of two, >=2)
AW, $clog2(DEPTH), buffer address width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
wr_en  input  1  buffer write strobe; honoured only in IDLE
wr_addr  input  AW  buffer write address
wr_data  input  32  buffer write data
start  input  1  start request; sampled only in IDLE
count  input  AW+1  words to process (0..DEPTH), sampled with start
busy  output  1  high in every state except IDLE
out_valid  output  1  result word available
out_ready  input  1  consumer accepts result
out_data  output  32  transformed word
out_index  output  AW  buffer index of out_data
done  output  1  one-cycle pulse at end of a run
err  output  1  one-cycle pulse: start with count>DEPTH

Behaviour:
- Reset (rst_n=0, async): state IDLE; busy, out_valid, done, err = 0; out_data, out_index, idx, in_reg = 0; all buffer entries cleared to 0. Reset mid-run aborts immediately; no done pulse.
- FSM states: IDLE, FETCH, XFORM, EMIT, FINISH.
- IDLE: wr_en writes buf[wr_addr]<=wr_data. On start: count>DEPTH -> err=1 next cycle, stay IDLE; count==0 -> FINISH; else latch cnt<=count, idx<=0, go FETCH. start and wr_en same cycle: write takes effect, run starts next cycle using updated contents.
- FETCH (1 cycle): in_reg<=buf[idx]; -> XFORM.
- XFORM (1 cycle): out_data<=manipular_vetores(in_reg); out_index<=idx; -> EMIT.
- EMIT: out_valid=1. out_data/out_index held stable while out_valid && !out_ready. On out_valid && out_ready: if idx==cnt-1 -> FINISH, else idx<=idx+1, -> FETCH. out_valid deasserts the cycle after handshake.
- FINISH (1 cycle): done=1; -> IDLE.
- Latency: start sampled at edge N -> out_valid first high after edge N+3; with out_ready held 1, one word per 3 cycles; done high the cycle after last handshake.
- wr_en and start outside IDLE are ignored (no buffer change, no restart).
- idx never wraps: terminates at cnt-1; count==DEPTH processes all entries.
- err and done never assert in the same cycle.

Decomposition:
- Package sequenciador_pkg: WORD_W=32, state enum (IDLE, FETCH, XFORM, EMIT, FINISH).
- One sub-module: the existing manipular_vetores, instantiated once, entrada=in_reg, saida feeds out_data register. Buffer and FSM stay inline.

Test Plan:
- Load buf = {0x12345678, 0xDEADBEEF, 0x00000000, 0xFFFFFFFF}, start count=4, out_ready=1 -> four transfers, out_index 0,1,2,3, out_data equal to manipular_vetores golden model of each word, first out_valid 3 cycles after start, done pulse one cycle after 4th handshake, busy low after.
- Same load, count=2, out_ready low for 5 cycles during first EMIT -> out_valid held, out_data/out_index stable at index 0 throughout; then exactly indices 0,1 delivered, done once.
- start count=0 -> no out_valid, done pulses 2 cycles after start; start count=5 (DEPTH=4) -> err 1-cycle pulse, busy stays 0, no done.
- During a run, wr_en to addr 1 with 0xCAFEBABE and a second start -> ignored: index 1 result matches original 0xDEADBEEF transform, only one done.
- Assert rst_n=0 mid-EMIT -> out_valid, busy, out_data drop to 0 immediately (no clk edge), no done; after release, buffer reads 0 and a count=1 run yields manipular_vetores(0x00000000).
